// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq: replays the shared OV7670 register ROM over one SCCB engine, left camera then right camera
// Ports:
//   clk_i, reset_i          clock and synchronous active-high reset
//   start_i                 one-cycle request to configure both cameras (ignored while busy)
//   rom_command_i/finished  ROM {reg, value} word and end marker, two-cycle latency
//   rom_resend_o/advance_o  rewind / step the ROM address
//   sccb_send_o/data_o      write request and command word, held until the engine acknowledges
//   sccb_sel_o              camera routed to the SCCB bus: 0 = left, 1 = right
//   sccb_busy_i             SCCB engine transaction in progress
//   cmd_count_o             commands written to the current camera, saturating at 255
//   busy_o, done_o          sequence running / both cameras configured
module ov7670_config_seq #(
  parameter int SETTLE_CYCLES = 25000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] rom_command_i,
  input  logic        rom_finished_i,
  output logic        rom_resend_o,
  output logic        rom_advance_o,
  output logic        sccb_send_o,
  output logic [15:0] sccb_data_o,
  output logic        sccb_sel_o,
  input  logic        sccb_busy_i,
  output logic [7:0]  cmd_count_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [15:0] COM7_RESET = 16'h1280;
  typedef enum logic [3:0] {IDLE, REWIND, ROM_WAIT, CHECK, SEND, WAIT_BUSY, SETTLE, ADVANCE, DONE} state_e;
  state_e state_q, state_d;
  logic wait_q, wait_d;
  logic sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [SW-1:0] settle_q, settle_d;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      wait_q   <= 1'b0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      settle_q <= settle_d;
    end
  end
  // wait_q marks the second ROM_WAIT cycle, covering the two-cycle ROM latency
  always_comb begin
    state_d  = state_q;
    wait_d   = (state_q == ROM_WAIT) && !wait_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    settle_d = settle_q;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = ROM_WAIT;
        sel_d   = 1'b0;
        cnt_d   = '0;
      end
      REWIND:   state_d = ROM_WAIT;
      ROM_WAIT: state_d = wait_q ? CHECK : ROM_WAIT;
      CHECK: begin
        if (rom_finished_i) begin
          state_d = sel_q ? DONE : REWIND;
          sel_d   = 1'b1;
          cnt_d   = sel_q ? cnt_q : '0;
        end else begin
          state_d = SEND;
          data_d  = rom_command_i;
        end
      end
      SEND:      state_d = sccb_busy_i ? WAIT_BUSY : SEND;
      WAIT_BUSY: if (!sccb_busy_i) begin
        cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        state_d  = (data_q == COM7_RESET) ? SETTLE : ADVANCE;
        settle_d = SETTLE_LOAD;
      end
      SETTLE: begin
        state_d  = (settle_q == '0) ? ADVANCE : SETTLE;
        settle_d = settle_q - 1'b1;
      end
      ADVANCE: state_d = ROM_WAIT;
      default: state_d = IDLE;
    endcase
  end
  assign rom_resend_o  = (state_q == IDLE) || (state_q == REWIND) || (state_q == DONE);
  assign rom_advance_o = state_q == ADVANCE;
  assign sccb_send_o   = state_q == SEND;
  assign sccb_data_o   = data_q;
  assign sccb_sel_o    = sel_q;
  assign cmd_count_o   = cnt_q;
  assign busy_o        = (state_q != IDLE) && (state_q != DONE);
  assign done_o        = state_q == DONE;
endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb_ov7670_config_seq: directed bench with ROM and SCCB engine models around ov7670_config_seq
module tb_ov7670_config_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [15:0] rom_command;
  logic rom_finished;
  logic rom_resend, rom_advance, sccb_send, sccb_sel, busy, done;
  logic [15:0] sccb_data;
  logic sccb_busy = 1'b0;
  logic [7:0] cmd_count;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  ov7670_config_seq #(.SETTLE_CYCLES(50)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .rom_command_i(rom_command), .rom_finished_i(rom_finished),
    .rom_resend_o(rom_resend), .rom_advance_o(rom_advance),
    .sccb_send_o(sccb_send), .sccb_data_o(sccb_data), .sccb_sel_o(sccb_sel),
    .sccb_busy_i(sccb_busy), .cmd_count_o(cmd_count), .busy_o(busy), .done_o(done)
  );
  logic [15:0] rom [0:63];
  int addr = 0;
  logic [15:0] d1 = 16'h0;
  logic [15:0] d2 = 16'h0;
  always @(posedge clk) begin
    if (rom_resend) addr <= 0;
    else if (rom_advance) addr <= addr + 1;
    d1 <= (addr < 64) ? rom[addr] : 16'hFFFF;
    d2 <= d1;
  end
  assign rom_command = d2;
  assign rom_finished = d2 == 16'hFFFF;
  int ack_dly = 2;
  int busy_len = 10;
  int ph = 0;
  int k = 0;
  int n_req = 0;
  logic [15:0] log_d [0:511];
  logic log_s [0:511];
  always @(posedge clk) begin
    case (ph)
      0: if (sccb_send) begin
        if (n_req < 512) begin
          log_d[n_req] = sccb_data;
          log_s[n_req] = sccb_sel;
        end
        n_req++;
        k = 1;
        if (k >= ack_dly - 1) begin sccb_busy <= 1'b1; ph = 2; k = 0; end
        else ph = 1;
      end
      1: begin
        k++;
        if (k >= ack_dly - 1) begin sccb_busy <= 1'b1; ph = 2; k = 0; end
      end
      2: begin
        k++;
        if (k >= busy_len) begin sccb_busy <= 1'b0; ph = 0; end
      end
      default: ph = 0;
    endcase
  end
  int cyc = 0;
  int fall_cyc = 0;
  int ng = 0;
  int gaps [0:15];
  int stab_err = 0;
  int run = 0;
  int nrun = 0;
  int runs [0:511];
  int sw_cnt = -1;
  logic prev_b = 1'b0, prev_cond = 1'b0, prev_sel = 1'b0;
  logic [15:0] prev_d = 16'h0;
  logic [7:0] prev_cnt = 8'h0;
  always @(posedge clk) begin
    cyc++;
    if (prev_b && !sccb_busy) fall_cyc = cyc;
    if (rom_advance && sccb_data == 16'h1280) begin
      if (ng < 16) gaps[ng] = cyc - fall_cyc;
      ng++;
    end
    if (prev_cond && sccb_data !== prev_d) stab_err++;
    if (sccb_send) run++;
    else if (run > 0) begin
      if (nrun < 512) runs[nrun] = run;
      nrun++;
      run = 0;
    end
    if (!prev_sel && sccb_sel) sw_cnt = int'(prev_cnt);
    prev_b = sccb_busy;
    prev_cond = sccb_send || sccb_busy;
    prev_d = sccb_data;
    prev_sel = sccb_sel;
    prev_cnt = cmd_count;
  end
  task automatic load4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rom_resend !== 1'b1) begin bad++; $display("FAIL reset_resend got=%b exp=1", rom_resend); end
    total++; if (rom_advance !== 1'b0) begin bad++; $display("FAIL reset_advance got=%b exp=0", rom_advance); end
    total++; if (sccb_send !== 1'b0) begin bad++; $display("FAIL reset_send got=%b exp=0", sccb_send); end
    total++; if (sccb_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", sccb_data); end
    total++; if (sccb_sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b exp=0", sccb_sel); end
    total++; if (cmd_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cmd_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask
  task automatic test_basic();
    logic [15:0] exp_d [0:2];
    int b, g;
    bit ok;
    exp_d[0] = 16'h1280; exp_d[1] = 16'h1100; exp_d[2] = 16'h8C00;
    load4(16'h1280, 16'h1100, 16'h8C00, 16'hFFFF);
    ack_dly = 2; busy_len = 10;
    b = n_req; g = ng;
    pulse_start();
    total++; if (busy !== 1'b1 || rom_resend !== 1'b0) begin bad++; $display("FAIL basic_k1 got busy=%b resend=%b exp busy=1 resend=0", busy, rom_resend); end
    repeat (2) @(negedge clk);
    total++; if (sccb_send !== 1'b0) begin bad++; $display("FAIL basic_k3_send got=%b exp=0", sccb_send); end
    @(negedge clk);
    total++; if (sccb_send !== 1'b1 || sccb_data !== 16'h1280 || sccb_sel !== 1'b0) begin bad++; $display("FAIL basic_k4 got send=%b data=%h sel=%b exp 1 1280 0", sccb_send, sccb_data, sccb_sel); end
    wait_done(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got done=%b exp=1", done); end
    total++; if (n_req - b !== 6) begin bad++; $display("FAIL basic_nreq got=%0d exp=6", n_req - b); end
    for (int i = 0; i < 6; i++) begin
      total++; if (log_d[b+i] !== exp_d[i%3] || log_s[b+i] !== (i >= 3)) begin bad++; $display("FAIL basic_req%0d got=%h/%b exp=%h/%b", i, log_d[b+i], log_s[b+i], exp_d[i%3], i >= 3); end
    end
    total++; if (ng - g !== 2) begin bad++; $display("FAIL basic_ngaps got=%0d exp=2", ng - g); end
    total++; if (gaps[g] !== 51 || gaps[g+1] !== 51) begin bad++; $display("FAIL basic_settle_gap got=%0d,%0d exp=51", gaps[g], gaps[g+1]); end
    total++; if (cmd_count !== 8'd3 || sw_cnt !== 3) begin bad++; $display("FAIL basic_count got=%0d/%0d exp=3/3", cmd_count, sw_cnt); end
    total++; if (busy !== 1'b0 || sccb_sel !== 1'b1) begin bad++; $display("FAIL basic_end got busy=%b sel=%b exp 0 1", busy, sccb_sel); end
  endtask
  task automatic test_full_rom();
    int b;
    bit ok;
    logic [7:0] ib;
    rom[0] = 16'h1280;
    for (int i = 1; i < 56; i++) begin ib = 8'(i); rom[i] = {ib, ~ib}; end
    for (int i = 56; i < 64; i++) rom[i] = 16'hFFFF;
    ack_dly = 2; busy_len = 3;
    b = n_req;
    pulse_start();
    wait_done(6000, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout got done=%b exp=1", done); end
    total++; if (n_req - b !== 112) begin bad++; $display("FAIL full_nreq got=%0d exp=112", n_req - b); end
    for (int i = 0; i < 112; i++) begin
      total++; if (log_d[b+i] !== rom[i%56] || log_s[b+i] !== (i >= 56)) begin bad++; $display("FAIL full_req%0d got=%h/%b exp=%h/%b", i, log_d[b+i], log_s[b+i], rom[i%56], i >= 56); end
    end
    total++; if (sw_cnt !== 56 || cmd_count !== 8'd56) begin bad++; $display("FAIL full_count got=%0d/%0d exp=56/56", sw_cnt, cmd_count); end
  endtask
  task automatic test_delayed_ack();
    int b, r;
    bit ok;
    load4(16'h1100, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    ack_dly = 20; busy_len = 5;
    b = n_req; r = nrun;
    pulse_start();
    wait_done(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL dly_timeout got done=%b exp=1", done); end
    total++; if (n_req - b !== 2 || nrun - r !== 2) begin bad++; $display("FAIL dly_nreq got=%0d runs=%0d exp=2", n_req - b, nrun - r); end
    total++; if (runs[r] !== 20 || runs[r+1] !== 20) begin bad++; $display("FAIL dly_send_len got=%0d,%0d exp=20", runs[r], runs[r+1]); end
    total++; if (log_d[b] !== 16'h1100 || log_d[b+1] !== 16'h1100) begin bad++; $display("FAIL dly_data got=%h,%h exp=1100", log_d[b], log_d[b+1]); end
    total++; if (cmd_count !== 8'd1) begin bad++; $display("FAIL dly_count got=%0d exp=1", cmd_count); end
  endtask
  task automatic test_reset_mid_settle();
    int b, t;
    bit ok;
    load4(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    ack_dly = 2; busy_len = 10;
    b = n_req;
    pulse_start();
    t = 0;
    while (n_req - b < 3 && t < 3000) begin @(negedge clk); t++; end
    total++; if (n_req - b !== 3) begin bad++; $display("FAIL rst_reach got=%0d exp=3", n_req - b); end
    t = 0;
    while (!sccb_busy && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (sccb_busy && t < 100) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b1 || sccb_sel !== 1'b1 || log_d[b+2] !== 16'h1280) begin bad++; $display("FAIL rst_pre got busy=%b sel=%b data=%h exp 1 1 1280", busy, sccb_sel, log_d[b+2]); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (rom_resend !== 1'b1 || sccb_send !== 1'b0 || sccb_sel !== 1'b0) begin bad++; $display("FAIL rst_outs got resend=%b send=%b sel=%b exp 1 0 0", rom_resend, sccb_send, sccb_sel); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || cmd_count !== 8'd0) begin bad++; $display("FAIL rst_status got busy=%b done=%b cnt=%0d exp 0 0 0", busy, done, cmd_count); end
    reset = 1'b0;
    b = n_req;
    pulse_start();
    wait_done(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_timeout got done=%b exp=1", done); end
    total++; if (n_req - b !== 4 || log_d[b] !== 16'h1280 || log_s[b] !== 1'b0) begin bad++; $display("FAIL rst_restart got n=%0d first=%h/%b exp 4 1280/0", n_req - b, log_d[b], log_s[b]); end
  endtask
  task automatic test_start_handling();
    logic [15:0] exp_d [0:2];
    int b;
    bit ok;
    exp_d[0] = 16'h1280; exp_d[1] = 16'h1100; exp_d[2] = 16'h8C00;
    load4(16'h1280, 16'h1100, 16'h8C00, 16'hFFFF);
    ack_dly = 2; busy_len = 10;
    b = n_req;
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    repeat (70) @(negedge clk);
    pulse_start();
    wait_done(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL start_timeout got done=%b exp=1", done); end
    total++; if (n_req - b !== 6) begin bad++; $display("FAIL start_busy_nreq got=%0d exp=6", n_req - b); end
    for (int i = 0; i < 6; i++) begin
      total++; if (log_d[b+i] !== exp_d[i%3] || log_s[b+i] !== (i >= 3)) begin bad++; $display("FAIL start_req%0d got=%h/%b exp=%h/%b", i, log_d[b+i], log_s[b+i], exp_d[i%3], i >= 3); end
    end
    total++; if (cmd_count !== 8'd3) begin bad++; $display("FAIL start_count got=%0d exp=3", cmd_count); end
    pulse_start();
    total++; if (done !== 1'b0 || busy !== 1'b1 || sccb_sel !== 1'b0 || cmd_count !== 8'd0) begin bad++; $display("FAIL start_in_done got done=%b busy=%b sel=%b cnt=%0d exp 0 1 0 0", done, busy, sccb_sel, cmd_count); end
    wait_done(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL start_timeout2 got done=%b exp=1", done); end
    total++; if (n_req - b !== 12 || log_d[b+6] !== 16'h1280 || log_s[b+6] !== 1'b0) begin bad++; $display("FAIL start_restart got n=%0d first=%h/%b exp 12 1280/0", n_req - b, log_d[b+6], log_s[b+6]); end
  endtask
  task automatic test_empty_rom();
    int b;
    load4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    b = n_req;
    pulse_start();
    repeat (2) @(negedge clk);
    total++; if (sccb_sel !== 1'b0) begin bad++; $display("FAIL empty_sel_k3 got=%b exp=0", sccb_sel); end
    @(negedge clk);
    total++; if (sccb_sel !== 1'b1 || rom_resend !== 1'b1) begin bad++; $display("FAIL empty_k4 got sel=%b resend=%b exp 1 1", sccb_sel, rom_resend); end
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL empty_k7 got done=%b busy=%b exp 0 1", done, busy); end
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL empty_k8 got done=%b busy=%b exp 1 0", done, busy); end
    total++; if (n_req - b !== 0 || cmd_count !== 8'd0) begin bad++; $display("FAIL empty_writes got n=%0d cnt=%0d exp 0 0", n_req - b, cmd_count); end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
    test_reset();
    test_basic();
    test_full_rom();
    test_delayed_ack();
    test_reset_mid_settle();
    test_start_handling();
    test_empty_rom();
    total++; if (stab_err !== 0) begin bad++; $display("FAIL data_stable got=%0d changes exp=0", stab_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ov7670_config_seq.md
# ov7670_config_seq

Sequencer that configures both OV7670 sensors of the stereo head from the single shared OV7670 register ROM through one shared SCCB write engine. It rewinds the ROM, reads each 16-bit {register, value} command, hands it to the SCCB engine with the selected camera routed, waits out the soft-reset settle time after COM7 reset writes, and advances the ROM until the end marker. It then repeats the whole sequence for the second camera. It sits between the top-level camera bring-up logic and the ROM/SCCB pair.

## Interface
- SETTLE_CYCLES, 25000, clock cycles to wait after a 16'h1280 (COM7 soft reset) write completes; ≥1 (25000 = 1 ms at 25 MHz)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to configure both cameras
- rom_command  in  16  ROM output, {reg addr, value}
- rom_finished  in  1  ROM end marker (command == 16'hFFFF)
- rom_resend  out  1  rewinds ROM address to 0
- rom_advance  out  1  one-cycle ROM address increment
- sccb_send  out  1  write request to SCCB engine
- sccb_data  out  16  command for the SCCB engine; stable while sccb_send=1
- sccb_sel  out  1  camera select for the SCCB bus mux: 0 = left, 1 = right
- sccb_busy  in  1  SCCB engine transaction in progress
- cmd_count  out  8  commands written to the current camera
- busy  out  1  sequence in progress
- done  out  1  both cameras configured; held until restart or reset

## Operation
- All outputs are decoded from registered state, with no combinational input-to-output paths.
- The ROM is treated as two-cycle latency: a resend or advance sampled at edge n yields valid rom_command/rom_finished after edge n+2.
- States:
  - IDLE: rom_resend=1, which keeps the ROM rewound. start → ROM_WAIT with sccb_sel=0 and cmd_count=0.
  - REWIND: rom_resend=1 for one cycle → ROM_WAIT.
  - ROM_WAIT: two cycles → CHECK.
  - CHECK:
    - If rom_finished and sccb_sel=0: set sccb_sel=1, clear cmd_count → REWIND.
    - If rom_finished and sccb_sel=1 → DONE.
    - Otherwise latch rom_command into sccb_data → SEND.
  - SEND: sccb_send=1 until sccb_busy=1 is sampled → WAIT_BUSY.
  - WAIT_BUSY: sccb_send=0. On sccb_busy=0, increment cmd_count. Then → SETTLE if sccb_data==16'h1280, else → ADVANCE.
  - SETTLE: count SETTLE_CYCLES cycles → ADVANCE.
  - ADVANCE: rom_advance=1 for one cycle → ROM_WAIT.
  - DONE: done=1, rom_resend=1. start → ROM_WAIT with sccb_sel=0, cmd_count=0, done cleared.
- busy=1 in every state except IDLE and DONE.
- start is ignored while busy=1.
- cmd_count saturates at 255. The settle counter is sized to clog2(SETTLE_CYCLES+1).
- Reset values: state IDLE, rom_resend=1, rom_advance=0, sccb_send=0, sccb_data=0, sccb_sel=0, cmd_count=0, busy=0, done=0.
- Reset in any state, including mid-SEND or mid-SETTLE, returns to IDLE on the next edge. The SCCB engine is left to finish its own transaction.
- A 16'hFFFF first entry means zero writes for that camera; sequencing proceeds normally.

## Timing
- start sampled at edge k (IDLE): ROM_WAIT during k+1..k+2, CHECK at k+3, sccb_send=1 from k+4.
- Request/acknowledge handshake:
  - sccb_send drops in the cycle after sccb_busy=1 is sampled.
  - At most one request per command.
  - sccb_data never changes while sccb_send=1 or sccb_busy=1.
- Per-command overhead with no settle: 1 (ADVANCE) + 2 (ROM_WAIT) + 1 (CHECK) cycles, plus the handshake and busy duration.
- After a 16'h1280 write: rom_advance pulses exactly SETTLE_CYCLES+1 cycles after sccb_busy=0 is sampled.
- Camera switch: CHECK → REWIND → 2× ROM_WAIT → CHECK, i.e. 4 cycles with sccb_sel=1 already stable.
- done rises the cycle after the final CHECK.

## Test plan
- **Basic two-camera sequence.** ROM model {1280, 1100, 8C00, FFFF}, SCCB model acks 2 cycles after send and stays busy 10 cycles, SETTLE_CYCLES=50 → sel=0 writes 1280, 1100, 8C00 in order, then sel=1 repeats them. Six requests total. Gap from busy fall after each 1280 to rom_advance is 51 cycles. done=1, cmd_count=3.
- **Full ROM image.** Full 56-entry image (0x00–0x37, 0x38 → FFFF) → 56 writes per camera, sequence matching the ROM order, cmd_count=56 at each end marker, 112 requests total.
- **Delayed acknowledge.** sccb_busy acknowledge delayed 20 cycles → sccb_send high for exactly 20 cycles, sccb_data constant, exactly one transaction.
- **Reset mid-settle.** Reset pulsed during SETTLE of camera 1 → next cycle: rom_resend=1, sccb_send=0, sel=0, busy=0, done=0. A new start begins again with 1280 on camera 0.
- **Start handling.** start while busy → no effect on sequence or counts. start in DONE → done=0 next cycle and the sequence restarts at camera 0.
- **Empty ROM.** ROM first entry FFFF → zero sccb_send pulses, sel toggles to 1, done=1 eight cycles after start is sampled.
